// File: rtl/arbitro_mux4.sv
// arbitro_mux4: 4-requester arbiter steering a 32-bit 4:1 mux; define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority (requester 0 highest)
module arbitro_mux4 (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] C,
    input  logic [31:0] D,
    input  logic        ready,
    output logic [1:0]  S,
    output logic [31:0] Y,
    output logic        valid,
    output logic [3:0]  grant,
    output logic [3:0]  ack
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic xfer;
    logic [3:0] cand;
    logic [1:0] win;
    assign valid = state == BUSY;
    assign xfer  = valid & ready;
    assign ack   = grant & {4{xfer}};
    assign Y     = S == 2'd0 ? A : S == 2'd1 ? B : S == 2'd2 ? C : D;
`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last, ptr, idx;
    // search from the slot after the pointer; a transferring owner is masked and becomes the pointer immediately
    always_comb begin
        ptr  = xfer ? S : last;
        cand = xfer ? req & ~grant : req;
        win  = ptr;
        idx  = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (cand[idx]) win = idx;
        end
    end
`else
    // pure fixed priority over all requests, lowest index wins
    always_comb begin
        cand = req;
        win  = 2'd0;
        for (int i = 3; i >= 0; i--) if (cand[i]) win = 2'(i);
    end
`endif
    // grant on idle request or on transfer; S keeps its last value when going idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            S     <= 2'd0;
            grant <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last  <= 2'd3;
`endif
        end else if (state == IDLE || ready) begin
            if (|cand) begin
                state <= BUSY;
                S     <= win;
                grant <= 4'b0001 << win;
            end else begin
                state <= IDLE;
                grant <= 4'd0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (xfer) last <= S;
`endif
        end
    end
endmodule

// File: doc/arbitro_mux4.md
ARBITRO_MUX4 -- requirements
Module: arbitro_mux4

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: req  input  4  request per requester i (bit i); held high until acknowledged.
REQ-005 Port: A, B, C, D  input  32 each  data of requesters 0..3; stable while corresponding req is high.
REQ-006 Port: ready  input  1  consumer accepts Y this cycle when valid=1.
REQ-007 Port: S  output  2  registered select index of current owner; drives a 4-input 32-bit mux.
REQ-008 Port: Y  output  32  selected data: A/B/C/D for S=0/1/2/3, combinational from S.
REQ-009 Port: valid  output  1  registered; Y holds a granted requester's data.
REQ-010 Port: grant  output  4  registered one-hot owner; all zero when valid=0.
REQ-011 Port: ack  output  4  combinational; ack[i] = grant[i] & valid & ready.

Function
REQ-012 States SHALL be IDLE (valid=0) and BUSY (valid=1, one grant bit set).
REQ-013 IDLE with req=0 -> stay IDLE; outputs S, grant unchanged-zero/previous S, valid=0.
REQ-014 IDLE with req!=0 -> next cycle BUSY; winner chosen by arbitration (REQ-017/REQ-018); S=winner index, grant=1<<winner, valid=1 (latency 1 cycle from req to valid).
REQ-015 BUSY with ready=0 -> hold S, grant, valid; req changes by the owner are ignored (owner SHALL NOT drop req before ack).
REQ-016 BUSY with ready=1 (transfer, ack[owner]=1) -> the owner's req bit SHALL be masked for arbitration that cycle; if any other req bit is set, next cycle stays BUSY with new winner (back-to-back, no bubble); else next cycle IDLE, grant=0, valid=0, S retains last value.
REQ-017 Arbitration SHALL use a 2-bit pointer last, updated to the winner on every transfer; search order is last+1, last+2, last+3, last (modulo 4, wrap 3->0).
REQ-018 Simultaneous requests SHALL be resolved in one cycle by REQ-017; owner re-requesting in transfer cycle is served only after other pending requesters.
REQ-019 grant SHALL always be one-hot or zero; grant!=0 iff valid=1.
REQ-020 Y SHALL reflect S every cycle regardless of valid.

Reset
REQ-021 On reset=1 at a clk edge: state=IDLE, valid=0, grant=4'b0000, S=2'b00, last=2'b11 (requester 0 first priority).
REQ-022 Reset mid-transfer SHALL abort the grant without ack; reset SHALL dominate req and ready in that cycle.
REQ-023 First arbitration SHALL occur on the first edge with reset=0 and req!=0.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN defined: arbitration per REQ-017 (round-robin).
REQ-025 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 highest, 3 lowest; last register absent; REQ-018 re-request rule replaced by pure priority; all other requirements unchanged.

Verification
REQ-026 reset=1 two cycles, then reset=0, req=0 -> valid=0, grant=0000, S=00, ack=0000 for 5 cycles.
REQ-027 req=0101, A=0x11111111, C=0x33333333, ready=1 held -> cycle+1 grant=0001 Y=0x11111111 ack=0001; cycle+2 grant=0100 Y=0x33333333; then IDLE when req=0000.
REQ-028 req=0010, B=0xDEADBEEF, ready=0 for 4 cycles then 1 -> valid=1, S=01, Y=0xDEADBEEF stable all 4 cycles; ack=0010 only on the ready cycle.
REQ-029 (ARB_ROUND_ROBIN_EN) req=1111 held, ready=1 -> grant sequence 0001,0010,0100,1000,0001 with no idle cycles; (undefined) grant stays 0001 every cycle.
REQ-030 req=1000, BUSY, reset=1 asserted with ready=0 -> next cycle valid=0, grant=0000, S=00, ack=0000; after release, req=1000 re-granted with 1-cycle latency.
